mem_stage_sram_ctrl: RTL and testbench



---
 rtl/mem_stage_sram_ctrl_pkg.sv | 25 ++
 rtl/mem_stage_sram_ctrl_if.sv | 27 ++
 rtl/mem_stage_sram_ctrl_sram_half_access.sv | 30 +++
 rtl/mem_stage_sram_ctrl.sv | 128 ++++++++++++
 tb/tb_mem_stage_sram_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM states, defaults and widths.
package mem_stage_sram_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LO   = 2'd1,
        S_HI   = 2'd2,
        S_DONE = 2'd3
    } mem_state_t;

    localparam int unsigned SRAM_WAIT_DEF = 2;
    localparam logic [31:0] MEM_BASE_DEF  = 32'd1024;

    localparam int unsigned ADDR_W = 18;
    localparam int unsigned WORD_W = 17;
    localparam int unsigned HALF_W = 16;
    localparam int unsigned CNT_W  = 4;

    // Byte address to 32-bit SRAM word index; upper bits are deliberately dropped.
    function automatic logic [WORD_W-1:0] word_addr(input logic [31:0] addr,
                                                    input logic [31:0] base);
        return WORD_W'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_if.sv
// External 16-bit SRAM bus between the MEM-stage controller (master) and the SRAM (slave).
interface mem_stage_sram_ctrl_if;
    import mem_stage_sram_ctrl_pkg::*;

    logic [ADDR_W-1:0] SRAM_ADDR;
    logic              SRAM_WE_N;
    logic [HALF_W-1:0] sram_dq_out;
    logic              sram_dq_oe;
    logic [HALF_W-1:0] sram_dq_in;

    modport master (
        output SRAM_ADDR,
        output SRAM_WE_N,
        output sram_dq_out,
        output sram_dq_oe,
        input  sram_dq_in
    );

    modport slave (
        input  SRAM_ADDR,
        input  SRAM_WE_N,
        input  sram_dq_out,
        input  sram_dq_oe,
        output sram_dq_in
    );

endinterface

// File: rtl/mem_stage_sram_ctrl_sram_half_access.sv
// Wait counter and per-half timing for one 16-bit SRAM half-access (shared by LO and HI).
module sram_half_access
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int unsigned WAIT = SRAM_WAIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_active,
    output logic o_strobe,
    output logic o_last
);

    logic [CNT_W-1:0] r_cnt;

    // Last cycle of a half is the capture point and the setup/hold gap for writes.
    assign o_last   = i_active && (r_cnt == CNT_W'(WAIT - 1));
    assign o_strobe = i_active && !o_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (!i_active || o_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// MEM pipeline stage driving a 16-bit SRAM as two half-word accesses per 32-bit load/store.
// Optional address range/alignment checking is enabled by defining MEM_ADDR_CHECK_EN.
module mem_stage_sram_ctrl
    import mem_stage_sram_ctrl_pkg::*;
#(
    parameter int unsigned SRAM_WAIT = SRAM_WAIT_DEF,
    parameter logic [31:0] MEM_BASE  = MEM_BASE_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        WB_EN_in,
    input  logic        MEM_R_EN_in,
    input  logic        MEM_W_EN_in,
    input  logic [3:0]  Dest_in,
    input  logic [31:0] ALU_Res_in,
    input  logic [31:0] Val_Rm_in,
    output logic        WB_EN_out,
    output logic        MEM_R_EN_out,
    output logic [3:0]  Dest_out,
    output logic [31:0] ALU_Res_out,
    output logic [31:0] Mem_Data_out,
    output logic        freeze,
`ifdef MEM_ADDR_CHECK_EN
    output logic        addr_err,
`endif
    mem_stage_sram_ctrl_if.master sram
);

    mem_state_t        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [HALF_W-1:0] r_lo_stage;
    logic [31:0]       r_mem_data;

    logic              w_req;
    logic              w_wr;
    logic              w_active;
    logic              w_strobe;
    logic              w_last;
    logic              w_addr_bad;
    logic [WORD_W-1:0] w_word;

    assign WB_EN_out    = WB_EN_in;
    assign MEM_R_EN_out = MEM_R_EN_in;
    assign Dest_out     = Dest_in;
    assign ALU_Res_out  = ALU_Res_in;

    assign w_req    = MEM_R_EN_in || MEM_W_EN_in;
    assign w_wr     = MEM_W_EN_in;
    assign w_active = (r_state == S_LO) || (r_state == S_HI);
    assign w_word   = word_addr(ALU_Res_in, MEM_BASE);

`ifdef MEM_ADDR_CHECK_EN
    logic [31:0] w_off;
    logic        r_addr_err;

    assign w_off      = ALU_Res_in - MEM_BASE;
    assign w_addr_bad = (ALU_Res_in < MEM_BASE) || (|w_off[31:WORD_W+2]) || (|ALU_Res_in[1:0]);
    assign addr_err   = r_addr_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr_err <= 1'b0;
        end else begin
            r_addr_err <= (r_state == S_IDLE) && w_req && w_addr_bad;
        end
    end
`else
    assign w_addr_bad = 1'b0;
`endif

    sram_half_access #(
        .WAIT (SRAM_WAIT)
    ) u_half (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_active (w_active),
        .o_strobe (w_strobe),
        .o_last   (w_last)
    );

    // Low half is staged so Mem_Data_out only changes when a whole read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_lo_stage <= '0;
            r_mem_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req && w_addr_bad) begin
                        r_state    <= S_DONE;
                        r_mem_data <= '0;
                    end else if (w_req) begin
                        r_state <= S_LO;
                        r_addr  <= {w_word, 1'b0};
                    end
                end
                S_LO: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        if (!w_wr) r_lo_stage <= sram.sram_dq_in;
                        r_addr  <= {w_word, 1'b1};
                        r_state <= S_HI;
                    end
                end
                S_HI: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                    end else if (w_last) begin
                        if (!w_wr) r_mem_data <= {sram.sram_dq_in, r_lo_stage};
                        r_state <= S_DONE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign freeze           = w_req && (r_state != S_DONE);
    assign Mem_Data_out     = r_mem_data;
    assign sram.SRAM_ADDR   = r_addr;
    assign sram.SRAM_WE_N   = !(w_wr && w_strobe);
    assign sram.sram_dq_oe  = w_wr && w_strobe;
    assign sram.sram_dq_out = (r_state == S_HI) ? Val_Rm_in[31:16] : Val_Rm_in[15:0];

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed bench for mem_stage_sram_ctrl with a behavioural 16-bit SRAM model (SRAM_WAIT=2).
module tb_mem_stage_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        WB_EN_in = 1'b0, MEM_R_EN_in = 1'b0, MEM_W_EN_in = 1'b0;
    logic [3:0]  Dest_in = '0;
    logic [31:0] ALU_Res_in = '0, Val_Rm_in = '0;
    logic        WB_EN_out, MEM_R_EN_out, freeze;
    logic [3:0]  Dest_out;
    logic [31:0] ALU_Res_out, Mem_Data_out;
`ifdef MEM_ADDR_CHECK_EN
    logic        addr_err;
`endif

    mem_stage_sram_ctrl_if sram_bus();

    mem_stage_sram_ctrl #(
        .SRAM_WAIT (2),
        .MEM_BASE  (32'd1024)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .WB_EN_in     (WB_EN_in),
        .MEM_R_EN_in  (MEM_R_EN_in),
        .MEM_W_EN_in  (MEM_W_EN_in),
        .Dest_in      (Dest_in),
        .ALU_Res_in   (ALU_Res_in),
        .Val_Rm_in    (Val_Rm_in),
        .WB_EN_out    (WB_EN_out),
        .MEM_R_EN_out (MEM_R_EN_out),
        .Dest_out     (Dest_out),
        .ALU_Res_out  (ALU_Res_out),
        .Mem_Data_out (Mem_Data_out),
        .freeze       (freeze),
`ifdef MEM_ADDR_CHECK_EN
        .addr_err     (addr_err),
`endif
        .sram         (sram_bus)
    );

    always #5 clk = ~clk;

    // SRAM model: synchronous write on WE_N low, asynchronous read.
    logic [15:0] mem [0:255] = '{default: 16'h0000};
    int          n_wr = 0;
    assign sram_bus.sram_dq_in = mem[sram_bus.SRAM_ADDR[7:0]];
    always @(posedge clk) begin
        if (!sram_bus.SRAM_WE_N) begin
            mem[sram_bus.SRAM_ADDR[7:0]] <= sram_bus.sram_dq_out;
            n_wr <= n_wr + 1;
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wb, r, w;
        logic [3:0]  dest;
        logic [31:0] alu;
        logic        exp_wb, exp_r;
        logic [3:0]  exp_dest;
        logic [31:0] exp_alu;
        logic        exp_freeze, exp_we_n;
    } vec_t;

    typedef struct {
        logic        freeze, we_n, oe;
        logic        chk_a;
        logic [17:0] addr;
        logic        chk_d;
        logic [15:0] dq;
        logic        chk_m;
        logic [31:0] md;
    } step_t;

    step_t seq [0:5];

    function automatic step_t st(input logic f, input logic we_n, input logic oe,
                                 input logic ca, input logic [17:0] a,
                                 input logic cd, input logic [15:0] d,
                                 input logic cm, input logic [31:0] m);
        step_t s;
        s.freeze = f; s.we_n = we_n; s.oe = oe;
        s.chk_a = ca; s.addr = a; s.chk_d = cd; s.dq = d; s.chk_m = cm; s.md = m;
        return s;
    endfunction

    task automatic fill_store(input logic [17:0] a, input logic [31:0] v);
        seq[0] = st(1, 1, 0, 0, '0,    0, '0,      0, '0);
        seq[1] = st(1, 0, 1, 1, a,     1, v[15:0],  0, '0);
        seq[2] = st(1, 1, 0, 1, a,     0, '0,      0, '0);
        seq[3] = st(1, 0, 1, 1, a + 1, 1, v[31:16], 0, '0);
        seq[4] = st(1, 1, 0, 1, a + 1, 0, '0,      0, '0);
        seq[5] = st(0, 1, 0, 1, a + 1, 0, '0,      0, '0);
    endtask

    task automatic fill_load(input logic [17:0] a, input logic [31:0] old_d, input logic [31:0] new_d);
        seq[0] = st(1, 1, 0, 0, '0,    0, '0, 1, old_d);
        seq[1] = st(1, 1, 0, 1, a,     0, '0, 1, old_d);
        seq[2] = st(1, 1, 0, 1, a,     0, '0, 1, old_d);
        seq[3] = st(1, 1, 0, 1, a + 1, 0, '0, 1, old_d);
        seq[4] = st(1, 1, 0, 1, a + 1, 0, '0, 1, old_d);
        seq[5] = st(0, 1, 0, 1, a + 1, 0, '0, 1, new_d);
    endtask

    // Inputs are already applied at a negedge; step k is checked 1 time unit after the k-th negedge.
    task automatic run_seq(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("%s[%0d].freeze", tag, k), 64'(freeze), 64'(seq[k].freeze));
            chk($sformatf("%s[%0d].we_n", tag, k), 64'(sram_bus.SRAM_WE_N), 64'(seq[k].we_n));
            chk($sformatf("%s[%0d].oe", tag, k), 64'(sram_bus.sram_dq_oe), 64'(seq[k].oe));
            if (seq[k].chk_a) chk($sformatf("%s[%0d].addr", tag, k), 64'(sram_bus.SRAM_ADDR), 64'(seq[k].addr));
            if (seq[k].chk_d) chk($sformatf("%s[%0d].dq", tag, k), 64'(sram_bus.sram_dq_out), 64'(seq[k].dq));
            if (seq[k].chk_m) chk($sformatf("%s[%0d].mdata", tag, k), 64'(Mem_Data_out), 64'(seq[k].md));
        end
    endtask

    task automatic set_in(input logic r, input logic w, input logic [31:0] alu, input logic [31:0] val);
        WB_EN_in = r; MEM_R_EN_in = r; MEM_W_EN_in = w;
        Dest_in = 4'd3; ALU_Res_in = alu; Val_Rm_in = val;
    endtask

    task automatic idle_in();
        WB_EN_in = 1'b0; MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0;
        Dest_in = '0; ALU_Res_in = '0; Val_Rm_in = '0;
    endtask

    vec_t vecs [0:4];
    int   wr_snap;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 4'h2, 32'h0000_0005, 1'b1, 1'b0, 4'h2, 32'h0000_0005, 1'b0, 1'b1};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 1'b0, 1'b0, 4'h0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 4'hF, 32'hFFFF_FFFF, 1'b1, 1'b0, 4'hF, 32'hFFFF_FFFF, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 4'hA, 32'h8000_0400, 1'b1, 1'b0, 4'hA, 32'h8000_0400, 1'b0, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 4'h5, 32'h1234_5678, 1'b0, 1'b0, 4'h5, 32'h1234_5678, 1'b0, 1'b1};

        // Reset state
        idle_in();
        @(negedge clk); #1;
        chk("rst.we_n",  64'(sram_bus.SRAM_WE_N),  64'd1);
        chk("rst.oe",    64'(sram_bus.sram_dq_oe), 64'd0);
        chk("rst.addr",  64'(sram_bus.SRAM_ADDR),  64'd0);
        chk("rst.mdata", 64'(Mem_Data_out),        64'd0);
        chk("rst.freeze", 64'(freeze),             64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Non-memory pass-through vectors
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            WB_EN_in = vecs[i].wb; MEM_R_EN_in = vecs[i].r; MEM_W_EN_in = vecs[i].w;
            Dest_in = vecs[i].dest; ALU_Res_in = vecs[i].alu; Val_Rm_in = 32'h0BAD_F00D;
            #1;
            chk($sformatf("vec%0d.pass", i), {WB_EN_out, MEM_R_EN_out, Dest_out, ALU_Res_out},
                {vecs[i].exp_wb, vecs[i].exp_r, vecs[i].exp_dest, vecs[i].exp_alu});
            chk($sformatf("vec%0d.freeze", i), 64'(freeze), 64'(vecs[i].exp_freeze));
            chk($sformatf("vec%0d.we_n", i), 64'(sram_bus.SRAM_WE_N), 64'(vecs[i].exp_we_n));
        end

        // Store 0xDEADBEEF to byte 1032 -> SRAM words 4/5
        @(negedge clk);
        set_in(1'b0, 1'b1, 32'd1032, 32'hDEAD_BEEF);
        fill_store(18'd4, 32'hDEAD_BEEF);
        run_seq("st1032", 6);
        idle_in();
        chk("st1032.mem4", 64'(mem[4]), 64'h BEEF);
        chk("st1032.mem5", 64'(mem[5]), 64'h DEAD);

        // Load it back
        @(negedge clk);
        set_in(1'b1, 1'b0, 32'd1032, 32'h0);
        fill_load(18'd4, 32'h0, 32'hDEAD_BEEF);
        run_seq("ld1032", 6);
        idle_in();

        // R and W together behave as a store
        @(negedge clk);
        set_in(1'b1, 1'b1, 32'd1040, 32'h2222_1111);
        fill_store(18'd8, 32'h2222_1111);
        run_seq("rw1040", 6);
        idle_in();
        chk("rw1040.mem8", 64'(mem[8]), 64'h1111);
        chk("rw1040.mem9", 64'(mem[9]), 64'h2222);

        // Store flushed in LO: strobe drops at once, nothing written, load data untouched
        @(negedge clk);
        set_in(1'b0, 1'b1, 32'd1040, 32'hCAFE_F00D);
        fill_store(18'd8, 32'hCAFE_F00D);
        run_seq("flush", 2);
        idle_in();
        #1;
        chk("flush.we_n_drop", 64'(sram_bus.SRAM_WE_N), 64'd1);
        chk("flush.freeze_drop", 64'(freeze), 64'd0);
        @(negedge clk); #1;
        chk("flush.oe_after", 64'(sram_bus.sram_dq_oe), 64'd0);
        chk("flush.mdata", 64'(Mem_Data_out), 64'hDEAD_BEEF);
        chk("flush.mem8", 64'(mem[8]), 64'h1111);

        // Fresh load after the flush takes the full access time
        @(negedge clk);
        set_in(1'b1, 1'b0, 32'd1040, 32'h0);
        fill_load(18'd8, 32'hDEAD_BEEF, 32'h2222_1111);
        run_seq("ld1040", 6);
        idle_in();

`ifdef MEM_ADDR_CHECK_EN
        // Load below MEM_BASE: straight to DONE with an error and zero data
        @(negedge clk);
        wr_snap = n_wr;
        set_in(1'b1, 1'b0, 32'd100, 32'h0);
        #1;
        chk("aerr.freeze0", 64'(freeze), 64'd1);
        chk("aerr.err0", 64'(addr_err), 64'd0);
        @(negedge clk); #1;
        chk("aerr.freeze1", 64'(freeze), 64'd0);
        chk("aerr.err1", 64'(addr_err), 64'd1);
        chk("aerr.mdata", 64'(Mem_Data_out), 64'd0);
        chk("aerr.we_n", 64'(sram_bus.SRAM_WE_N), 64'd1);
        chk("aerr.nwr", 64'(n_wr), 64'(wr_snap));
        idle_in();
`endif

        // Reset during HI of a store to 1048 (words 12/13)
        @(negedge clk);
        set_in(1'b0, 1'b1, 32'd1048, 32'h1234_5678);
        fill_store(18'd12, 32'h1234_5678);
        run_seq("rsthi", 4);
        wr_snap = n_wr;
        rst_n = 1'b0;
        #1;
        chk("rsthi.we_n", 64'(sram_bus.SRAM_WE_N), 64'd1);
        chk("rsthi.oe", 64'(sram_bus.sram_dq_oe), 64'd0);
        chk("rsthi.addr", 64'(sram_bus.SRAM_ADDR), 64'd0);
        chk("rsthi.freeze", 64'(freeze), 64'd1);
        repeat (2) @(negedge clk);
        #1;
        chk("rsthi.we_n_hold", 64'(sram_bus.SRAM_WE_N), 64'd1);
        idle_in();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk); #1;
        chk("rsthi.nwr", 64'(n_wr), 64'(wr_snap));
        chk("rsthi.mem12", 64'(mem[12]), 64'h5678);
        chk("rsthi.mem13", 64'(mem[13]), 64'h0000);
        chk("rsthi.mdata", 64'(Mem_Data_out), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
